// File: rtl/stream_demux_router_if.sv
// Stream bundle for the demux router: one merged ingress stream with ID/QoS
// sidebands and STREAM_COUNT egress streams. The router uses the slave modport;
// the environment feeding it and draining its outputs uses the master modport.
interface stream_demux_router_if #(
  parameter int STREAM_COUNT = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) ();

  logic [T_DATA_WIDTH-1:0] s_data;
  logic [T_QOS__WIDTH-1:0] s_qos;
  logic [T_ID___WIDTH-1:0] s_id;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;

  logic [T_DATA_WIDTH-1:0] m_data [STREAM_COUNT-1:0];
  logic [T_QOS__WIDTH-1:0] m_qos  [STREAM_COUNT-1:0];
  logic [STREAM_COUNT-1:0] m_last;
  logic [STREAM_COUNT-1:0] m_valid;
  logic [STREAM_COUNT-1:0] m_ready;

  modport master (
    output s_data, s_qos, s_id, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_qos, m_last, m_valid
  );

  modport slave (
    input  s_data, s_qos, s_id, s_last, s_valid, m_ready,
    output s_ready, m_data, m_qos, m_last, m_valid
  );

endinterface

// File: rtl/stream_demux_router.sv
// Egress demux: routes each packet of the merged stream to the output picked
// by its first-beat ID, holding that route until tlast. Each output has a
// one-deep register slice; packets with an out-of-range ID are discarded and
// counted in a saturating counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// FIRST | waiting for the first beat of a packet; route taken from s_id
// BODY  | mid-packet, every beat goes to lock_id regardless of s_id
// DROP  | mid-packet with an invalid ID, beats are swallowed until tlast
module stream_demux_router #(
  parameter int STREAM_COUNT = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  stream_demux_router_if.slave  bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    BODY  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [T_ID___WIDTH-1:0] lock_id, lock_id_nxt;
  logic [T_ID___WIDTH-1:0] route_id;
  logic                    load_en;
  logic                    drop_inc;
  logic                    s_ready_c;

  logic [STREAM_COUNT-1:0] slot_valid;
  logic [STREAM_COUNT-1:0] slot_last;
  logic [T_DATA_WIDTH-1:0] slot_data [STREAM_COUNT-1:0];
  logic [T_QOS__WIDTH-1:0] slot_qos  [STREAM_COUNT-1:0];

  logic [STREAM_COUNT-1:0] free_vec;
  logic                    free_at_sid;
  logic                    free_at_lock;
  logic                    id_ok;

  // A slot can take a beat when empty or being drained this cycle.
  assign free_vec = ~slot_valid | bus.m_ready;
  assign id_ok    = (int'(bus.s_id) < STREAM_COUNT);

  // Look up slot availability by index without ever indexing out of range.
  always_comb begin
    free_at_sid  = 1'b0;
    free_at_lock = 1'b0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      if (bus.s_id == T_ID___WIDTH'(k)) free_at_sid  = free_vec[k];
      if (lock_id  == T_ID___WIDTH'(k)) free_at_lock = free_vec[k];
    end
  end

  // Next-state, ingress ready and slot-load decision.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    route_id    = lock_id;
    s_ready_c   = 1'b0;
    load_en     = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      FIRST: begin
        if (id_ok) begin
          route_id  = bus.s_id;
          s_ready_c = free_at_sid;
          if (bus.s_valid && free_at_sid) begin
            load_en = 1'b1;
            if (!bus.s_last) begin
              lock_id_nxt = bus.s_id;
              state_nxt   = BODY;
            end
          end
        end else begin
          s_ready_c = 1'b1;
          if (bus.s_valid) begin
            drop_inc = 1'b1;
            if (!bus.s_last) state_nxt = DROP;
          end
        end
      end
      BODY: begin
        s_ready_c = free_at_lock;
        if (bus.s_valid && free_at_lock) begin
          load_en = 1'b1;
          if (bus.s_last) state_nxt = FIRST;
        end
      end
      DROP: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && bus.s_last) state_nxt = FIRST;
      end
      default: state_nxt = FIRST;
    endcase
  end

  assign bus.s_ready = s_ready_c;

  // FSM state, locked route and saturating drop counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= FIRST;
      lock_id  <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Per-output register slices: load wins over drain so back-to-back beats stream.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_valid <= '0;
      slot_last  <= '0;
      for (int k = 0; k < STREAM_COUNT; k++) begin
        slot_data[k] <= '0;
        slot_qos[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STREAM_COUNT; k++) begin
        if (load_en && (route_id == T_ID___WIDTH'(k))) begin
          slot_valid[k] <= 1'b1;
          slot_last[k]  <= bus.s_last;
          slot_data[k]  <= bus.s_data;
          slot_qos[k]   <= bus.s_qos;
        end else if (bus.m_ready[k]) begin
          slot_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.m_valid = slot_valid;
  assign bus.m_last  = slot_last;

  for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_out
    assign bus.m_data[g] = slot_data[g];
    assign bus.m_qos[g]  = slot_qos[g];
  end

endmodule

// File: tb/tb_stream_demux_router.sv
// Directed bench for the stream demux router: a 4-output instance for routing,
// backpressure and ID locking, and a 3-output instance with a 2-bit drop
// counter for the invalid-ID path and counter saturation.
module tb_stream_demux_router;

  logic clk;
  logic nrst;
  logic [7:0] dc4;
  logic [1:0] dc3;

  int checks;
  int errors;

  stream_demux_router_if #(.STREAM_COUNT(4)) bus4 ();
  stream_demux_router_if #(.STREAM_COUNT(3)) bus3 ();

  stream_demux_router #(.STREAM_COUNT(4)) dut4 (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bus4.slave),
    .drop_cnt (dc4)
  );

  stream_demux_router #(.STREAM_COUNT(3), .DROP_CNT_W(2)) dut3 (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bus3.slave),
    .drop_cnt (dc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [1:0] id, input logic [7:0] d, input logic l);
    bus4.s_valid = v;
    bus4.s_id    = id;
    bus4.s_data  = d;
    bus4.s_qos   = d[3:0];
    bus4.s_last  = l;
  endtask

  task automatic drive3(input logic v, input logic [1:0] id, input logic [7:0] d, input logic l);
    bus3.s_valid = v;
    bus3.s_id    = id;
    bus3.s_data  = d;
    bus3.s_qos   = d[3:0];
    bus3.s_last  = l;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    checks = 0;
    errors = 0;
    nrst = 1'b1;
    drive4(0, 0, 8'h00, 0);
    drive3(0, 0, 8'h00, 0);
    bus4.m_ready = 4'b1111;
    bus3.m_ready = 3'b111;
    #1 nrst = 1'b0;
    #20;
    chk("rst_mvalid4", 32'(bus4.m_valid), 32'h0);
    chk("rst_mdata4_2", 32'(bus4.m_data[2]), 32'h0);
    chk("rst_mlast4", 32'(bus4.m_last), 32'h0);
    chk("rst_dc3", 32'(dc3), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    next_cycle();

    // 1: three-beat packet to output 2, all outputs ready
    drive4(1, 2, 8'hA1, 0);
    @(negedge clk);
    chk("t1_ready", 32'(bus4.s_ready), 32'h1);
    chk("t1_mv_pre", 32'(bus4.m_valid), 32'h0);
    next_cycle();
    drive4(1, 2, 8'hB2, 0);
    @(negedge clk);
    chk("t1_mv_a", 32'(bus4.m_valid), 32'b0100);
    chk("t1_data_a", 32'(bus4.m_data[2]), 32'hA1);
    chk("t1_qos_a", 32'(bus4.m_qos[2]), 32'h1);
    chk("t1_last_a", 32'(bus4.m_last[2]), 32'h0);
    next_cycle();
    drive4(1, 2, 8'hC3, 1);
    @(negedge clk);
    chk("t1_mv_b", 32'(bus4.m_valid), 32'b0100);
    chk("t1_data_b", 32'(bus4.m_data[2]), 32'hB2);
    chk("t1_last_b", 32'(bus4.m_last[2]), 32'h0);
    next_cycle();
    drive4(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t1_mv_c", 32'(bus4.m_valid), 32'b0100);
    chk("t1_data_c", 32'(bus4.m_data[2]), 32'hC3);
    chk("t1_last_c", 32'(bus4.m_last[2]), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("t1_mv_end", 32'(bus4.m_valid), 32'h0);
    next_cycle();

    // 2: backpressure on output 1
    bus4.m_ready = 4'b1101;
    drive4(1, 1, 8'hD4, 0);
    @(negedge clk);
    chk("t2_ready_first", 32'(bus4.s_ready), 32'h1);
    next_cycle();
    drive4(1, 1, 8'hE5, 1);
    @(negedge clk);
    chk("t2_mv_hold1", 32'(bus4.m_valid), 32'b0010);
    chk("t2_data_hold1", 32'(bus4.m_data[1]), 32'hD4);
    chk("t2_ready_hold1", 32'(bus4.s_ready), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t2_data_hold2", 32'(bus4.m_data[1]), 32'hD4);
    chk("t2_ready_hold2", 32'(bus4.s_ready), 32'h0);
    next_cycle();
    bus4.m_ready = 4'b1111;
    @(negedge clk);
    chk("t2_ready_rel", 32'(bus4.s_ready), 32'h1);
    chk("t2_data_rel", 32'(bus4.m_data[1]), 32'hD4);
    next_cycle();
    drive4(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t2_mv_second", 32'(bus4.m_valid), 32'b0010);
    chk("t2_data_second", 32'(bus4.m_data[1]), 32'hE5);
    chk("t2_last_second", 32'(bus4.m_last[1]), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("t2_mv_end", 32'(bus4.m_valid), 32'h0);
    next_cycle();

    // 3: packet locked to output 0 while s_id wanders to 3
    drive4(1, 0, 8'hF0, 0);
    @(negedge clk);
    chk("t3_ready", 32'(bus4.s_ready), 32'h1);
    next_cycle();
    drive4(1, 3, 8'h61, 0);
    @(negedge clk);
    chk("t3_mv_1", 32'(bus4.m_valid), 32'b0001);
    chk("t3_data_1", 32'(bus4.m_data[0]), 32'hF0);
    next_cycle();
    drive4(1, 3, 8'h72, 0);
    @(negedge clk);
    chk("t3_mv_2", 32'(bus4.m_valid), 32'b0001);
    chk("t3_data_2", 32'(bus4.m_data[0]), 32'h61);
    next_cycle();
    drive4(1, 0, 8'h83, 1);
    @(negedge clk);
    chk("t3_mv_3", 32'(bus4.m_valid), 32'b0001);
    chk("t3_data_3", 32'(bus4.m_data[0]), 32'h72);
    next_cycle();
    drive4(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t3_mv_4", 32'(bus4.m_valid), 32'b0001);
    chk("t3_data_4", 32'(bus4.m_data[0]), 32'h83);
    chk("t3_last_4", 32'(bus4.m_last[0]), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("t3_mv_end", 32'(bus4.m_valid), 32'h0);
    next_cycle();

    // 4: N=3, four-beat packet with id 3 is dropped, then id 1 routes normally
    drive3(1, 3, 8'h90, 0);
    @(negedge clk);
    chk("t4_ready_0", 32'(bus3.s_ready), 32'h1);
    chk("t4_dc_0", 32'(dc3), 32'h0);
    next_cycle();
    drive3(1, 3, 8'h91, 0);
    @(negedge clk);
    chk("t4_ready_1", 32'(bus3.s_ready), 32'h1);
    chk("t4_mv_1", 32'(bus3.m_valid), 32'h0);
    chk("t4_dc_1", 32'(dc3), 32'h1);
    next_cycle();
    drive3(1, 3, 8'h92, 0);
    @(negedge clk);
    chk("t4_ready_2", 32'(bus3.s_ready), 32'h1);
    chk("t4_dc_2", 32'(dc3), 32'h1);
    next_cycle();
    drive3(1, 3, 8'h93, 1);
    @(negedge clk);
    chk("t4_ready_3", 32'(bus3.s_ready), 32'h1);
    chk("t4_mv_3", 32'(bus3.m_valid), 32'h0);
    chk("t4_dc_3", 32'(dc3), 32'h1);
    next_cycle();
    drive3(1, 1, 8'hA4, 1);
    @(negedge clk);
    chk("t4_ready_next", 32'(bus3.s_ready), 32'h1);
    chk("t4_mv_next_pre", 32'(bus3.m_valid), 32'h0);
    next_cycle();
    drive3(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t4_mv_next", 32'(bus3.m_valid), 32'b010);
    chk("t4_data_next", 32'(bus3.m_data[1]), 32'hA4);
    chk("t4_dc_after", 32'(dc3), 32'h1);
    next_cycle();

    // 5: 2-bit drop counter saturates after five dropped single-beat packets
    nrst = 1'b0;
    @(negedge clk);
    chk("t5_dc_rst", 32'(dc3), 32'h0);
    nrst = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive3(1, 3, 8'(i), 1);
      next_cycle();
      drive3(0, 0, 8'h00, 0);
      @(negedge clk);
      chk($sformatf("t5_dc_%0d", i), 32'(dc3), 32'(sat_exp[i]));
      chk($sformatf("t5_mv_%0d", i), 32'(bus3.m_valid), 32'h0);
      next_cycle();
    end

    // 6: async reset mid-packet with output 0 occupied
    bus4.m_ready = 4'b1110;
    drive4(1, 0, 8'hC7, 0);
    next_cycle();
    drive4(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t6_mv_pre", 32'(bus4.m_valid), 32'b0001);
    chk("t6_data_pre", 32'(bus4.m_data[0]), 32'hC7);
    #1 nrst = 1'b0;
    #1;
    chk("t6_mv_rst", 32'(bus4.m_valid), 32'h0);
    chk("t6_data_rst", 32'(bus4.m_data[0]), 32'h0);
    chk("t6_dc3_rst", 32'(dc3), 32'h0);
    chk("t6_dc4_rst", 32'(dc4), 32'h0);
    #1 nrst = 1'b1;
    bus4.m_ready = 4'b1111;
    next_cycle();
    drive4(1, 1, 8'hD8, 1);
    @(negedge clk);
    chk("t6_ready_after", 32'(bus4.s_ready), 32'h1);
    next_cycle();
    drive4(0, 0, 8'h00, 0);
    @(negedge clk);
    chk("t6_mv_after", 32'(bus4.m_valid), 32'b0010);
    chk("t6_data_after", 32'(bus4.m_data[1]), 32'hD8);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
